data_mem_responder: RTL and testbench

//   Data-memory responder serving the pipeline's MEM-stage load/store requests (rd_en/wd_en/addr/din/mem_type).

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for MEM-stage loads/stores: byte/half/word lanes, load extension and
// programmable read wait states. Define DMEM_MISALIGN_CHK_EN to flag and suppress misaligned accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        mem_type,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitLast = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   lat_idx_q;
  logic [1:0]        lat_off_q;
  logic [2:0]        lat_type_q;
  logic              lat_mis_q;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic [31:0]       mem [DEPTH];

  logic              idle;
  logic [IdxW-1:0]   req_idx;
  logic [1:0]        req_off;
  logic              req_mis;
  logic              store_fire;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic [31:0]       merged;
  logic [IdxW-1:0]   rsel_idx;
  logic [1:0]        rsel_off;
  logic [2:0]        rsel_type;
  logic              rsel_mis;
  logic [31:0]       raw_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic              unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:IdxW+2];
  assign idle        = (state_q == StIdle);
  assign req_idx     = addr[IdxW+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign req_mis = ((mem_type[1:0] == 2'b01) && addr[0]) || (mem_type[1] && (addr[1:0] != 2'b00));
`else
  assign req_mis = 1'b0;
`endif

  // Low offset bits are forced aligned for halves and words.
  always_comb begin
    req_off = addr[1:0];
    wmask   = 4'b1111;
    wdata   = din;
    if (mem_type[1]) begin
      req_off = 2'b00;
    end else if (mem_type[0]) begin
      req_off = {addr[1], 1'b0};
      wmask   = 4'b0011 << req_off;
      wdata   = {2{din[15:0]}};
    end else begin
      wmask   = 4'b0001 << req_off;
      wdata   = {4{din[7:0]}};
    end
  end

  assign store_fire = idle && wd_en && !req_mis;

  always_comb begin
    merged = mem[req_idx];
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (store_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[req_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // With zero wait states the response is formed at the accept edge, so a simultaneous
  // store is forwarded to give write-first behaviour.
  assign rsel_idx  = idle ? req_idx  : lat_idx_q;
  assign rsel_off  = idle ? req_off  : lat_off_q;
  assign rsel_type = idle ? mem_type : lat_type_q;
  assign rsel_mis  = idle ? req_mis  : lat_mis_q;
  assign raw_word  = store_fire ? merged : mem[rsel_idx];
  assign shifted   = raw_word >> {rsel_off, 3'b000};

  always_comb begin
    case (rsel_type[1:0])
      2'b00:   load_val = rsel_type[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = rsel_type[2] ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (rd_en) begin
          cnt_d   = 4'd0;
          state_d = (WAIT_CYC > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) state_d = StResp;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    if (state_d == StResp) dout_d = rsel_mis ? 32'b0 : load_val;
    err_d = (idle && wd_en && req_mis) || ((state_d == StResp) && rsel_mis);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      lat_idx_q  <= '0;
      lat_off_q  <= 2'b00;
      lat_type_q <= 3'b000;
      lat_mis_q  <= 1'b0;
      dout_q     <= 32'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      if (idle && rd_en) begin
        lat_idx_q  <= req_idx;
        lat_off_q  <= req_off;
        lat_type_q <= mem_type;
        lat_mis_q  <= req_mis;
      end
    end
  end

  assign busy     = !idle;
  assign rd_valid = (state_q == StResp);
  assign dout     = dout_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 3 wait states) against a byte-addressed
// reference memory, with directed steps followed by random traffic.
module tb_data_mem_responder;

`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en, wd_en, rd_valid, busy, err;
  logic [31:0] addr [2];
  logic [2:0]  mt   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];

  int n_checks = 0;
  int n_errors = 0;
  int wc [2] = '{0, 3};
  logic [7:0] mm [2][1024];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wd_en(wd_en[0]), .addr(addr[0]),
    .mem_type(mt[0]), .din(din[0]), .dout(dout[0]), .rd_valid(rd_valid[0]),
    .busy(busy[0]), .err(err[0])
  );

  data_mem_responder #(.DEPTH(256), .ADDR_W(32), .WAIT_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wd_en(wd_en[1]), .addr(addr[1]),
    .mem_type(mt[1]), .din(din[1]), .dout(dout[1]), .rd_valid(rd_valid[1]),
    .busy(busy[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] t);
    if (t[1:0] == 2'b00) return 1;
    if (t[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit mis_of(input logic [31:0] a, input logic [2:0] t);
    return Chk && ((a & 32'(nbytes(t) - 1)) != 0);
  endfunction

  // Byte address within the 1 KiB space, rounded down to the access size.
  function automatic int base_of(input logic [31:0] a, input logic [2:0] t);
    int n;
    n = nbytes(t);
    return (int'(a % 1024) / n) * n;
  endfunction

  task automatic model_store(input int i, input logic [31:0] a, input logic [2:0] t,
                             input logic [31:0] d);
    int b;
    if (mis_of(a, t)) return;
    b = base_of(a, t);
    for (int k = 0; k < nbytes(t); k++) mm[i][b + k] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] model_load(input int i, input logic [31:0] a,
                                             input logic [2:0] t);
    logic [31:0] v;
    int b;
    if (mis_of(a, t)) return 32'b0;
    b = base_of(a, t);
    v = 32'b0;
    for (int k = 0; k < nbytes(t); k++) v[8*k +: 8] = mm[i][b + k];
    if (!t[2] && nbytes(t) == 1) v = {{24{v[7]}}, v[7:0]};
    if (!t[2] && nbytes(t) == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic access(input int i, input bit rd, input bit wd, input logic [31:0] a,
                        input logic [2:0] t, input logic [31:0] d, input bit interfere);
    bit          m;
    logic [31:0] exp;
    int          cyc;
    m = mis_of(a, t);
    if (wd) model_store(i, a, t, d);
    exp = model_load(i, a, t);
    @(negedge clk);
    rd_en[i] = rd; wd_en[i] = wd; addr[i] = a; mt[i] = t; din[i] = d;
    @(negedge clk);
    rd_en[i] = 1'b0; wd_en[i] = 1'b0;
    if (wd) check("store_err", 32'(err[i]), 32'(m));
    if (!rd) begin
      check("store_busy", 32'(busy[i]), 32'd0);
      return;
    end
    cyc = 1;
    while (rd_valid[i] !== 1'b1 && cyc < 40) begin
      check("busy_inflight", 32'(busy[i]), 32'd1);
      if (interfere && cyc == 1) begin
        wd_en[i] = 1'b1; din[i] = ~d; mt[i] = 3'b010;
      end else begin
        wd_en[i] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    wd_en[i] = 1'b0;
    check("load_latency", 32'(cyc), 32'(1 + wc[i]));
    check("resp_rd_valid", 32'(rd_valid[i]), 32'd1);
    check("resp_busy", 32'(busy[i]), 32'd1);
    check("resp_dout", dout[i], exp);
    check("resp_err", 32'(err[i]), 32'(m));
    @(negedge clk);
    check("post_rd_valid", 32'(rd_valid[i]), 32'd0);
    check("post_busy", 32'(busy[i]), 32'd0);
    check("post_dout_hold", dout[i], exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  t;
    int          i, op;

    rst = 1'b0; rd_en = '0; wd_en = '0;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; mt[k] = '0; din[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_dout", dout[k], 32'd0);
      check("reset_rd_valid", 32'(rd_valid[k]), 32'd0);
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_err", 32'(err[k]), 32'd0);
    end
    rst = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 64; w++) access(k, 0, 1, 32'(w * 4), 3'b010, $urandom, 0);

    // Word store then load, zero wait states.
    access(0, 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 0);
    access(0, 1, 0, 32'h10, 3'b010, 32'h0, 0);
    check("t1_dout", dout[0], 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads, neighbouring lanes untouched.
    access(0, 0, 1, 32'h20, 3'b011, 32'h11223344, 0);
    access(0, 0, 1, 32'h21, 3'b000, 32'h00000080, 0);
    access(0, 1, 0, 32'h21, 3'b000, 32'h0, 0);
    check("t2_signed", dout[0], 32'hFFFFFF80);
    access(0, 1, 0, 32'h21, 3'b100, 32'h0, 0);
    check("t2_unsigned", dout[0], 32'h00000080);
    access(0, 1, 0, 32'h20, 3'b010, 32'h0, 0);
    check("t2_word", dout[0], 32'h11228044);

    // Three wait states; a store attempted while busy must be dropped.
    access(1, 0, 1, 32'h30, 3'b010, 32'hCAFEF00D, 0);
    access(1, 1, 0, 32'h30, 3'b010, 32'h0, 1);
    access(1, 1, 0, 32'h30, 3'b010, 32'h0, 0);
    check("t3_unchanged", dout[1], 32'hCAFEF00D);

    // Simultaneous load and store returns the stored data.
    access(0, 1, 1, 32'h40, 3'b010, 32'h12345678, 0);
    check("t4_write_first", dout[0], 32'h12345678);
    access(1, 1, 1, 32'h44, 3'b001, 32'h0000F00D, 0);
    check("t4_write_first_wait", dout[1], 32'hFFFFF00D);

    // Reset during an in-flight load aborts it.
    @(negedge clk);
    rd_en[1] = 1'b1; addr[1] = 32'h30; mt[1] = 3'b010;
    @(negedge clk);
    rd_en[1] = 1'b0;
    check("t5_busy_before", 32'(busy[1]), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_busy_async", 32'(busy[1]), 32'd0);
    check("t5_dout_async", dout[1], 32'd0);
    check("t5_rd_valid_async", 32'(rd_valid[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_no_pulse", 32'(rd_valid[1]), 32'd0);
    end
    access(1, 1, 0, 32'h30, 3'b010, 32'h0, 0);
    check("t5_next_load", dout[1], 32'hCAFEF00D);

    // Misaligned accesses.
    access(0, 0, 1, 32'h00, 3'b010, 32'hA5A55A5A, 0);
    access(0, 0, 1, 32'h03, 3'b001, 32'h0000BEEF, 0);
    access(0, 1, 0, 32'h00, 3'b010, 32'h0, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    check("t6_word0", dout[0], 32'hA5A55A5A);
`else
    check("t6_word0", dout[0], 32'hBEEF5A5A);
`endif
    access(0, 1, 0, 32'h02, 3'b010, 32'h0, 0);
`ifdef DMEM_MISALIGN_CHK_EN
    check("t6_misaligned_load", dout[0], 32'h0);
`else
    check("t6_forced_align", dout[0], 32'hBEEF5A5A);
`endif

    // Random traffic; upper address bits are noise and must wrap.
    for (int n = 0; n < 300; n++) begin
      i  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
      t  = 3'($urandom);
      d  = $urandom;
      access(i, op != 0, op != 1, a, t, d, i == 1 && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
